// File: rtl/arm_fetch_pkg.sv
// rtl/arm_fetch_pkg.sv - shared types and constants for the instruction prefetch front-end
package arm_fetch_pkg;

  typedef enum logic {FETCH, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched {pc, instr} entries; flush beats push/pop
module fetch_fifo
  import arm_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap on natural overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// rtl/instr_prefetch.sv - req/ack instruction fetcher feeding the core through a small FIFO
// Define FETCH_PERF_EN to add the perf_stall / perf_flush counters.
module instr_prefetch
  import arm_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall,
  output logic [15:0] perf_flush
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   drain_addr;
  logic          active;
  logic          push;
  logic          pop;
  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    push      = 1'b0;
    if (state == FETCH) begin
      imem_req = active && (count < CW'(DEPTH));
      push     = imem_req && imem_ack && !redirect;
      if (redirect && imem_req && !imem_ack) state_nxt = DRAIN;
    end else begin
      // the abandoned request must still complete at its original address
      imem_req  = 1'b1;
      imem_addr = drain_addr;
      if (imem_ack) state_nxt = FETCH;
    end
  end

  // active holds off the first request for one cycle after reset release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
      active     <= 1'b0;
    end else begin
      active <= 1'b1;
      if (redirect)  fetch_pc <= redirect_pc & ~32'h3;
      else if (push) fetch_pc <= fetch_pc + 32'(WORD_BYTES);
      if (state == FETCH && state_nxt == DRAIN) drain_addr <= fetch_pc;
    end
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign entry.pc    = fetch_pc;
  assign entry.instr = imem_rdata;
  assign instr       = instr_valid ? head.instr : 32'h0;
  assign instr_pc    = instr_valid ? head.pc : 32'h0;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .entry (entry),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .count (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (instr_ready && !instr_valid) perf_stall <= perf_stall + 1'b1;
      if (redirect)                    perf_flush <= perf_flush + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
// tb/tb_instr_prefetch.sv - directed self-checking bench for instr_prefetch
module tb_instr_prefetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;
`endif

  logic [7:0] lat;
  logic [7:0] wcnt;
  logic       mem_hold;
  int         n_cmp;
  int         n_bad;
  int         n;
  int         acks;

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: ack after lat extra cycles of a held request; data is a function of address
  assign imem_ack   = imem_req && !mem_hold && (wcnt >= lat);
  assign imem_rdata = imem_addr ^ 32'hE5A0_0000;

  always @(posedge clk or negedge reset) begin
    if (!reset)        wcnt <= 8'd0;
    else if (imem_ack) wcnt <= 8'd0;
    else if (imem_req) wcnt <= wcnt + 8'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b1; lat = 8'd0; mem_hold = 1'b0;

    // reset values, then zero-wait streaming
    tick(); #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    reset = 1'b1;
    tick(); #1;
    check("t1_valid0", instr_valid, 0);
    check("t1_req", imem_req, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      check("t1_valid", instr_valid, 1);
      check("t1_pc", instr_pc, 32'(i * 4));
      check("t1_instr", instr, 32'(i * 4) ^ 32'hE5A0_0000);
    end

    // FIFO fills to DEPTH while the core stalls, then drains in order
    instr_ready = 1'b0;
    do_reset();
    acks = 0;
    repeat (10) begin
      #1;
      if (imem_ack) acks++;
      tick();
    end
    #1;
    check("t2_acks", 32'(acks), 32'd4);
    check("t2_req_full", imem_req, 0);
    check("t2_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check("t2_pc", instr_pc, 32'(i * 4));
      tick(); #1;
    end

    // redirect while a 3-wait request to 0x8 is outstanding
    instr_ready = 1'b0; lat = 8'd3;
    do_reset();
    n = 0; #1;
    while (!(imem_req && imem_addr == 32'h8) && n < 40) begin
      tick(); #1; n++;
    end
    check("t3_reach8", 32'(n < 40), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
    tick(); redirect = 1'b0; #1;
    check("t3_c2_addr", imem_addr, 32'h8);
    check("t3_c2_valid", instr_valid, 0);
    tick(); #1;
    check("t3_c3_req", imem_req, 1);
    check("t3_c3_addr", imem_addr, 32'h8);
    tick(); #1;
    check("t3_c4_ack", imem_ack, 1);
    check("t3_c4_addr", imem_addr, 32'h8);
    tick(); #1;
    check("t3_refetch_req", imem_req, 1);
    check("t3_refetch_addr", imem_addr, 32'h40);
    check("t3_refetch_valid", instr_valid, 0);
    n = 0;
    while (!instr_valid && n < 20) begin
      tick(); #1; n++;
    end
    check("t3_first_pc", instr_pc, 32'h40);
    check("t3_first_instr", instr, 32'h40 ^ 32'hE5A0_0000);

    // redirect coinciding with ack and pop; unaligned target
    lat = 8'd0; instr_ready = 1'b1;
    do_reset();
    tick(); tick(); tick(); #1;
    check("t4_pre", {30'h0, instr_valid, imem_ack}, 32'h3);
    check("t4_pre_pc", instr_pc, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick(); redirect = 1'b0; #1;
    check("t4_valid0", instr_valid, 0);
    check("t4_addr", imem_addr, 32'h100);
    check("t4_req", imem_req, 1);
    tick(); #1;
    check("t4_pc0", instr_pc, 32'h100);
    tick(); #1;
    check("t4_pc1", instr_pc, 32'h104);

    // reset asserted mid-stream with a request pending
    lat = 8'd3; instr_ready = 1'b0;
    do_reset();
    n = 0; #1;
    while (!instr_valid && n < 40) begin
      tick(); #1; n++;
    end
    check("t5_pending", {30'h0, imem_req, imem_ack}, 32'h2);
    reset = 1'b0; #1;
    check("t5_req", imem_req, 0);
    check("t5_addr", imem_addr, 32'h0);
    check("t5_valid", instr_valid, 0);
    check("t5_instr", instr, 32'h0);
    check("t5_pc", instr_pc, 32'h0);
    lat = 8'd0; instr_ready = 1'b1;
    tick(); tick(); reset = 1'b1;
    tick(); #1;
    check("t5_restart_valid0", instr_valid, 0);
    tick(); #1;
    check("t5_restart_pc", instr_pc, 32'h0);
    check("t5_restart_valid", instr_valid, 1);

`ifdef FETCH_PERF_EN
    mem_hold = 1'b1; instr_ready = 1'b0;
    do_reset(); #1;
    check("t6_stall0", perf_stall, 32'h0);
    check("t6_flush0", 32'(perf_flush), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h20;
    tick(); tick(); tick();
    redirect = 1'b0; instr_ready = 1'b1;
    repeat (5) tick();
    instr_ready = 1'b0; #1;
    check("t6_flush", 32'(perf_flush), 32'd3);
    check("t6_stall", perf_stall, 32'd5);
    mem_hold = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
